// File: rtl/layer_weight_buffer_pkg.sv
// Shared defaults, boolean constants and state encoding for the layer weight buffer.
package layer_weight_buffer_pkg;

  localparam int INPUT_LAYER_NODES = 784;
  localparam int RELU_NODES        = 10;
  localparam int LAYER_1_BIT_WIDTH = 8;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    WB_IDLE    = 2'd0,
    WB_LOADING = 2'd1,
    WB_READY   = 2'd2
  } wb_state_t;

endpackage

// File: rtl/layer_weight_buffer_row_ram.sv
// Weight row storage: one synchronous write port, one synchronous read port, no reset on the array.
module weight_row_ram #(
  parameter int DEPTH  = 784,
  parameter int WIDTH  = 80,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  // Callers only present in-range addresses, so the low index bits are sufficient.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr[IDX_W-1:0]] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr[IDX_W-1:0]];
  end

endmodule

// File: rtl/layer_weight_buffer.sv
// Streaming-loaded weight store with a load-complete handshake and a 1-cycle registered read port.
module layer_weight_buffer
  import layer_weight_buffer_pkg::*;
#(
  parameter int NODES     = INPUT_LAYER_NODES,
  parameter int LANES     = RELU_NODES,
  parameter int BIT_WIDTH = LAYER_1_BIT_WIDTH,
  parameter int ADDR_W    = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_start,
  input  logic                       load_valid,
  input  logic [LANES*BIT_WIDTH-1:0] load_data,
  output logic                       load_ready,
  output logic                       load_done,
  output logic                       weights_valid,
  input  logic                       read_en,
  input  logic [ADDR_W-1:0]          read_addr,
  output logic [LANES*BIT_WIDTH-1:0] read_data,
  output logic                       read_valid,
  output logic                       read_err
);

  localparam int                ROW_W    = LANES * BIT_WIDTH;
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NODES - 1);

  wb_state_t         state, state_next;
  logic [ADDR_W-1:0] wr_ptr;
  logic              wr_en, last_accept;
  logic              rd_accept, rd_in_range, ram_rd_en;
  logic              zero_out;
  logic [ROW_W-1:0]  ram_q;

  assign load_ready    = (state == WB_LOADING);
  assign weights_valid = (state == WB_READY);

  // A restart pulse discards any row presented alongside it.
  assign wr_en       = load_ready & load_valid & ~load_start & ~reset;
  assign last_accept = wr_en & (wr_ptr == LAST_ROW);

  assign rd_accept   = read_en & weights_valid & ~reset;
  assign rd_in_range = (read_addr <= LAST_ROW);
  assign ram_rd_en   = rd_accept & rd_in_range;

  weight_row_ram #(
    .DEPTH  (NODES),
    .WIDTH  (ROW_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (load_data),
    .rd_en   (ram_rd_en),
    .rd_addr (read_addr),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= WB_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      WB_IDLE:    if (load_start) state_next = WB_LOADING;
      WB_LOADING: begin
        if (load_start)       state_next = WB_LOADING;
        else if (last_accept) state_next = WB_READY;
      end
      WB_READY:   if (load_start) state_next = WB_LOADING;
      default:    state_next = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      load_done <= FALSE;
    end else begin
      load_done <= last_accept;
      if (load_start)
        wr_ptr <= '0;
      else if (wr_en && wr_ptr != LAST_ROW)
        wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // The RAM output register holds between reads; zero_out forces the reset and
  // out-of-range value without needing a reset on the RAM itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_valid <= FALSE;
      read_err   <= FALSE;
      zero_out   <= TRUE;
    end else begin
      read_valid <= rd_accept;
      read_err   <= rd_accept & ~rd_in_range;
      if (rd_accept) zero_out <= ~rd_in_range;
    end
  end

  assign read_data = zero_out ? '0 : ram_q;

endmodule
